// File: rtl/apb_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_rst_seq: APB-programmable staggered reset sequencer for NUM_DOM      |
// | domains. Optional rst_req_n synchronizer: APB_RST_SEQ_SYNC_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_rst_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DOM    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  penable,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  rst_req_n,
  output logic [NUM_DOM-1:0]    dom_rst_n,
  output logic                  seq_busy,
  output logic                  seq_irq
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_wait = 1'b1;

  localparam logic [7:0] c_addr_ctrl   = 8'h00;
  localparam logic [7:0] c_addr_delay  = 8'h04;
  localparam logic [7:0] c_addr_status = 8'h08;

  logic [0:0]            r_state, w_state_next;
  logic                  r_en, r_irq_en, r_done, r_irq;
  logic [CNT_WIDTH-1:0]  r_delay, r_cnt, w_cnt_next;
  logic [NUM_DOM-1:0]    r_dom, w_dom_next, w_dom_step, w_goal, w_hi;
  logic [DATA_WIDTH-1:0] r_prdata, w_rdata;
  logic                  w_req, w_tgt, w_busy, w_done_set, w_wr, w_rd;
  logic                  w_unused;

`ifdef APB_RST_SEQ_SYNC_EN
  logic [1:0] r_req_sync;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_req_sync <= '0;
    else          r_req_sync <= {r_req_sync[0], rst_req_n};
  end

  assign w_req = r_req_sync[1];
`else
  assign w_req = rst_req_n;
`endif

  assign w_tgt    = r_en & w_req;
  assign w_goal   = w_tgt ? '1 : '0;
  assign w_wr     = psel & penable & pwrite;
  assign w_rd     = psel & ~penable & ~pwrite;
  assign w_unused = ^{paddr, pwdata};

  // Highest released domain, as a one-hot mask.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < NUM_DOM; i++)
      if (r_dom[i]) w_hi = NUM_DOM'(1) << i;
  end

  // Release fills the lowest zero bit; assert clears the highest one bit.
  assign w_dom_step = w_tgt ? (r_dom | (~r_dom & (r_dom + 1'b1))) : (r_dom & ~w_hi);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= c_st_idle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (r_dom != w_goal) w_state_next = c_st_wait;
      c_st_wait: if (r_cnt == '0 && w_dom_step == w_goal) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_dom_next = r_dom;
    w_cnt_next = r_cnt;
    w_done_set = 1'b0;
    w_busy     = (r_state == c_st_wait);
    case (r_state)
      c_st_idle: if (r_dom != w_goal) w_cnt_next = r_delay;
      c_st_wait: begin
        if (r_cnt == '0) begin
          w_dom_next = w_dom_step;
          if (w_dom_step == w_goal) w_done_set = 1'b1;
          else                      w_cnt_next = r_delay;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (paddr[7:0])
      c_addr_ctrl:  w_rdata[1:0] = {r_irq_en, r_en};
      c_addr_delay: w_rdata[CNT_WIDTH-1:0] = r_delay;
      c_addr_status: begin
        w_rdata[0]            = w_busy;
        w_rdata[1]            = r_done;
        w_rdata[8 +: NUM_DOM] = r_dom;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_dom    <= '0;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_delay  <= CNT_WIDTH'(8'hFF);
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
      r_prdata <= '0;
    end else begin
      r_dom <= w_dom_next;
      r_cnt <= w_cnt_next;
      if (w_wr && paddr[7:0] == c_addr_ctrl)  {r_irq_en, r_en} <= pwdata[1:0];
      if (w_wr && paddr[7:0] == c_addr_delay) r_delay <= pwdata[CNT_WIDTH-1:0];
      // A completing step beats a same-cycle W1C.
      if (w_done_set)                                           r_done <= 1'b1;
      else if (w_wr && paddr[7:0] == c_addr_status && pwdata[1]) r_done <= 1'b0;
      r_irq <= r_done & r_irq_en;
      if (w_rd) r_prdata <= w_rdata;
    end
  end

  assign prdata    = r_prdata;
  assign dom_rst_n = r_dom;
  assign seq_busy  = w_busy;
  assign seq_irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_apb_rst_seq.sv
`default_nettype none
// Self-checking bench for apb_rst_seq: directed steps plus randomized delays
// checked against an arithmetic release/assert schedule.
module tb_apb_rst_seq;

  localparam int NUM_DOM    = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 16;
`ifdef APB_RST_SEQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic                  pclk      = 1'b0;
  logic                  presetn   = 1'b0;
  logic                  psel      = 1'b0;
  logic                  pwrite    = 1'b0;
  logic                  penable   = 1'b0;
  logic                  rst_req_n = 1'b0;
  logic [ADDR_WIDTH-1:0] paddr     = '0;
  logic [DATA_WIDTH-1:0] pwdata    = '0;
  logic [DATA_WIDTH-1:0] prdata;
  logic [NUM_DOM-1:0]    dom_rst_n;
  logic                  seq_busy, seq_irq;

  apb_rst_seq #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_DOM(NUM_DOM), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .penable(penable), .prdata(prdata),
    .rst_req_n(rst_req_n), .dom_rst_n(dom_rst_n), .seq_busy(seq_busy),
    .seq_irq(seq_irq)
  );

  always #5 pclk = ~pclk;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
    tick();
    data = prdata;
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  // Domains changed t cycles after the target flips: first at D+2, then every D+1.
  function automatic int steps_done(input int t, input int d);
    int k;
    if (t < d + 2) return 0;
    k = 1 + (t - d - 2) / (d + 1);
    return (k > NUM_DOM) ? NUM_DOM : k;
  endfunction

  function automatic logic [31:0] exp_dom(input int t, input int d, input bit rel);
    int k;
    k = steps_done(t, d);
    return rel ? 32'((1 << k) - 1) : 32'((1 << (NUM_DOM - k)) - 1);
  endfunction

  task automatic run_seq(input string tag, input int d, input bit rel, input int t0,
                         input bit chk_irq);
    int last;
    last = d + 2 + (NUM_DOM - 1) * (d + 1);
    for (int t = 1; t <= last + 2; t++) begin
      tick_to(t0 + t);
      chk({tag, "_dom"}, 32'(dom_rst_n), exp_dom(t, d, rel));
      chk({tag, "_busy"}, 32'(seq_busy), 32'(steps_done(t, d) < NUM_DOM));
      if (chk_irq) chk({tag, "_irq"}, 32'(seq_irq), 32'(t >= last + 1));
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          t0;
    int          d;

    // Reset state
    tick(); tick();
    chk("rst_dom", 32'(dom_rst_n), 32'h0);
    chk("rst_busy", 32'(seq_busy), 32'h0);
    chk("rst_irq", 32'(seq_irq), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    presetn = 1'b1;
    tick();
    apb_read(32'h00, rd); chk("rd_ctrl", rd, 32'h0);
    apb_read(32'h04, rd); chk("rd_delay", rd, 32'hFF);
    apb_read(32'h08, rd); chk("rd_status", rd, 32'h0);
    apb_read(32'h0C, rd); chk("rd_unmapped", rd, 32'h0);

    // CTRL-driven release with DELAY=3, interrupt enabled
    rst_req_n = 1'b1;
    repeat (4) tick();
    apb_write(32'h04, 32'd3);
    apb_write(32'h00, 32'h3);
    t0 = cyc;
    run_seq("rel3", 3, 1'b1, t0, 1'b1);
    apb_read(32'h08, rd); chk("status_done", rd, 32'hF02);

    // Randomized delays, alternating assert/release through rst_req_n
    for (int i = 0; i < 5; i++) begin
      d = int'($urandom_range(0, 4));
      apb_write(32'h04, 32'(d));
      repeat ($urandom_range(0, 3)) tick();
      rst_req_n = (i % 2 == 1);
      t0 = cyc + SYNC_LAT;
      run_seq("rnd", d, rst_req_n, t0, 1'b0);
    end

    // Direction reversal mid-release: en dropped while 0011
    apb_write(32'h04, 32'd10);
    rst_req_n = 1'b1;
    t0 = cyc + SYNC_LAT;
    tick_to(t0 + 11); chk("rev_pre", 32'(dom_rst_n), 32'h0);
    tick_to(t0 + 12); chk("rev_d0", 32'(dom_rst_n), 32'h1);
    tick_to(t0 + 23); chk("rev_d1", 32'(dom_rst_n), 32'h3);
    tick_to(t0 + 24);
    apb_write(32'h00, 32'h2);
    tick_to(t0 + 33); chk("rev_hold", 32'(dom_rst_n), 32'h3);
    chk("rev_busy", 32'(seq_busy), 32'h1);
    tick_to(t0 + 34); chk("rev_a1", 32'(dom_rst_n), 32'h1);
    tick_to(t0 + 44); chk("rev_hold2", 32'(dom_rst_n), 32'h1);
    tick_to(t0 + 45); chk("rev_a0", 32'(dom_rst_n), 32'h0);
    chk("rev_idle", 32'(seq_busy), 32'h0);

    // Same-cycle done set and W1C: set wins
    apb_write(32'h08, 32'h2);
    apb_read(32'h08, rd); chk("w1c_pre", rd, 32'h0);
    apb_write(32'h04, 32'd3);
    apb_write(32'h00, 32'h3);
    t0 = cyc;
    tick_to(t0 + 15);
    apb_write(32'h08, 32'h2);
    chk("coll_dom", 32'(dom_rst_n), 32'hF);
    apb_read(32'h08, rd); chk("coll_done", rd, 32'hF02);
    chk("coll_irq", 32'(seq_irq), 32'h1);
    apb_write(32'h08, 32'h2);
    tick();
    chk("w1c_irq", 32'(seq_irq), 32'h0);
    apb_read(32'h08, rd); chk("w1c_status", rd, 32'hF00);

    // Asynchronous reset mid-sequence
    rst_req_n = 1'b0;
    t0 = cyc + SYNC_LAT;
    tick_to(t0 + 20); chk("ar_all", 32'(dom_rst_n), 32'h0);
    rst_req_n = 1'b1;
    t0 = cyc + SYNC_LAT;
    tick_to(t0 + 13);
    chk("ar_pre_dom", 32'(dom_rst_n), 32'h7);
    chk("ar_pre_busy", 32'(seq_busy), 32'h1);
    #2 presetn = 1'b0;
    #1;
    chk("ar_dom", 32'(dom_rst_n), 32'h0);
    chk("ar_busy", 32'(seq_busy), 32'h0);
    chk("ar_prdata", prdata, 32'h0);
    presetn = 1'b1;
    tick();
    apb_read(32'h04, rd); chk("ar_delay", rd, 32'hFF);
    apb_read(32'h00, rd); chk("ar_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_rst_seq.md
# apb_rst_seq

APB-programmable reset sequencer that releases and re-asserts `NUM_DOM` downstream reset domains in a fixed order with a programmable inter-step delay. It sits behind the PMU: the PMU's `sys_rst_n` drives `rst_req_n`, and this block turns that single level into staggered per-domain resets. Domains release in order 0 to `NUM_DOM-1` and assert in reverse order. Software sees progress through a status register and an optional completion interrupt.

## Interface
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `NUM_DOM`, 4: number of reset domains, 1..8.
- `CNT_WIDTH`, 16: width of the delay counter.

- `pclk`  input  1  APB/system clock; the only clock.
- `presetn`  input  1  reset, asynchronous, active-low.
- `psel`  input  1  APB select.
- `paddr`  input  ADDR_WIDTH  APB address; only `[7:0]` is decoded.
- `pwrite`  input  1  APB write.
- `pwdata`  input  DATA_WIDTH  APB write data.
- `penable`  input  1  APB enable.
- `prdata`  output  DATA_WIDTH  APB read data, registered.
- `rst_req_n`  input  1  reset request level from the PMU; 1 = release requested.
- `dom_rst_n`  output  NUM_DOM  per-domain reset, active-low, registered.
- `seq_busy`  output  1  sequence in progress.
- `seq_irq`  output  1  level interrupt, registered.

## Operation
- APB write strobe: `psel & penable & pwrite`. Read strobe: `psel & !penable & !pwrite`, which loads `prdata` at the setup edge. Unmapped reads return 0; unmapped writes are ignored.
- Register map (offsets on `paddr[7:0]`):
  - 0x00 CTRL (RW): bit0 `en`, bit1 `irq_en`. Reset value 0.
  - 0x04 DELAY (RW): bits `[CNT_WIDTH-1:0]`. Reset value 0x00FF.
  - 0x08 STATUS: bit0 `busy` (RO), bit1 `done` (W1C), bits `[8+NUM_DOM-1:8]` = `dom_rst_n` (RO).
- Target level: `tgt = en & rst_req_n`. Sequence goal: all domains released when `tgt=1`, all domains in reset when `tgt=0`.
- FSM states: IDLE, WAIT.
  - IDLE to WAIT: when `dom_rst_n` is not at its goal. `cnt` loads DELAY and `busy` is set.
  - WAIT: `cnt` decrements each cycle.
  - Step, on a WAIT cycle with `cnt==0`, with `tgt` re-evaluated at that step:
    - `tgt=1`: deassert the lowest-index asserted domain.
    - `tgt=0`: assert the highest-index released domain.
  - After a step, if `dom_rst_n` now equals the goal: go to IDLE, clear `busy`, set `done`. Otherwise reload `cnt` from DELAY and stay in WAIT.
- A change of `tgt` mid-sequence reverses direction at the next step. There is no restart, and the counter is not reloaded early.
- A DELAY write mid-sequence takes effect at the next reload.
- `done` set and a W1C clear in the same cycle: set wins.
- `seq_irq` is registered `done & irq_en`.

## Timing
- Reset values: `dom_rst_n` = 0 (all domains in reset), `seq_busy` = 0, `seq_irq` = 0, `prdata` = 0, FSM in IDLE, `cnt` = 0.
- With DELAY = D, the first domain changes D+2 cycles after `tgt` changes in IDLE:
  - one cycle for the IDLE→WAIT edge;
  - D+1 cycles in WAIT.
- Each subsequent domain changes every D+1 cycles.
- D=0: one domain changes per cycle after the first.
- `seq_busy` rises on the IDLE→WAIT edge and falls on the same edge as the final domain change.
- `seq_irq` follows `done` by one cycle.
- `presetn` asserted mid-sequence: all outputs and state return to their reset values immediately, asynchronously.

## Configuration
- `APB_RST_SEQ_SYNC_EN`:
  - Defined: `rst_req_n` passes through a two-flop synchronizer (reset value 0) before forming `tgt`. This adds 2 cycles of latency to every `rst_req_n` response.
  - Undefined: `rst_req_n` is used directly and must be synchronous to `pclk`.
  - CTRL-driven latency is identical in both builds.

## Test plan
- Reset, then read 0x00/0x04/0x08 → 0x0, 0xFF, 0x0; `dom_rst_n` = 4'b0000.
- `rst_req_n=1`, DELAY=3, write CTRL=0x3 → `dom_rst_n` steps 0001, 0011, 0111, 1111 at write+5, +9, +13, +17 cycles (no-sync build). `done` sets on the last step; `seq_irq` rises one cycle later.
- From all released, drive `rst_req_n=0` → domains assert in order 3, 2, 1, 0 every D+1 cycles.
- DELAY=10, release sequence running with `dom_rst_n`=0011 → set `en=0` → the next step asserts domain 1, then domain 0.
- Write STATUS with bit1 set on the same cycle a sequence completes → `done` reads 1. A later W1C clears `done` and `seq_irq`.
- Assert `presetn` with `dom_rst_n`=0111 and `busy=1` → `dom_rst_n`=0 and `busy`=0 with no clock edge.
